vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: consecutive denied CPU-request cycles before the CPU is forced to win.
REQ-002 SHALL have parameter AW, default 15: RAM address width (32k x 8 video RAM).
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port vblank  in  1  high = vertical blank, CPU has priority.
REQ-006 SHALL have port vid_req  in  1  video fetch request.
REQ-007 SHALL have port vid_addr  in  AW  video read address.
REQ-008 SHALL have port vid_ack  out  1  video access performed this cycle.
REQ-009 SHALL have port vid_valid  out  1  video read data valid.
REQ-010 SHALL have port vid_data  out  8  video read data.
REQ-011 SHALL have port cpu_req  in  1  CPU access request.
REQ-012 SHALL have port cpu_we  in  1  1 = write, 0 = read.
REQ-013 SHALL have port cpu_addr  in  AW  CPU address.
REQ-014 SHALL have port cpu_din  in  8  CPU write data.
REQ-015 SHALL have port cpu_ack  out  1  CPU access performed this cycle.
REQ-016 SHALL have port cpu_valid  out  1  CPU read data valid.
REQ-017 SHALL have port cpu_dout  out  8  CPU read data, held.
REQ-018 SHALL have port ram_we  out  1  RAM write enable.
REQ-019 SHALL have port ram_addr  out  AW  RAM address.
REQ-020 SHALL have port ram_din  out  8  RAM write data.
REQ-021 SHALL have port ram_dout  in  8  RAM registered read data (1-cycle latency; not updated on write cycles).

Function
REQ-022 SHALL grant at most one requester per cycle; grant is combinational from the current-cycle req inputs and the registered starve count.
REQ-023 SHALL use this priority: starve count == STARVE_MAX -> CPU; else vblank=1 -> CPU; else video; no other requester.
REQ-024 SHALL grant a lone requester in the same cycle it asserts req.
REQ-025 SHALL assert ack in the granted cycle only; ack = req & grant, never without req.
REQ-026 SHALL drive ram_addr/ram_we/ram_din from the granted requester; video grant forces ram_we=0; no grant -> ram_we=0, ram_addr holds its last value.
REQ-027 SHALL perform one access per acked cycle; a req held high yields back-to-back accesses, one per cycle.
REQ-028 SHALL pulse vid_valid exactly one cycle after vid_ack, with vid_data = ram_dout in that cycle.
REQ-029 SHALL pulse cpu_valid one cycle after a CPU read ack (cpu_we=0); a CPU write ack SHALL produce no cpu_valid.
REQ-030 SHALL present cpu_dout = ram_dout during the cpu_valid cycle, then hold that value until the next cpu_valid.
REQ-031 SHALL track a one-bit pending-read owner register that routes the returning data; writes do not load it.
REQ-032 SHALL increment a saturating starve counter (width clog2(STARVE_MAX+1)) when cpu_req=1 and cpu_ack=0; clear it on cpu_ack or cpu_req=0.
REQ-033 SHALL, with STARVE_MAX=0, disable the starvation override so video always wins outside vblank.
REQ-034 SHALL leave the CPU or video requester stalled indefinitely if it drops req before ack; no queuing or latching of requests.

Reset
REQ-035 SHALL, while reset=1 at a clock edge, clear the starve counter, pending flags, vid_valid, cpu_valid, cpu_dout=0x00, and ram_addr=0.
REQ-036 SHALL ignore requests while reset is high (no ack, ram_we=0); an access acked in the cycle before reset asserts produces no valid.

Structure
REQ-037 SHALL place the grant-select encoding (NONE/VID/CPU) and the AW default in shared package vram_pkg.
REQ-038 SHALL be a single module with no sub-modules; the RAM itself is instantiated outside, by the parent.

Verification
REQ-039 SHALL cover: vid_req only, addr 0x0123, RAM[0x0123]=0x5A -> vid_ack same cycle; vid_valid next cycle with vid_data=0x5A.
REQ-040 SHALL cover: both reqs continuously high, vblank=0, STARVE_MAX=3 -> ack pattern V,V,V,C repeating.
REQ-041 SHALL cover: vblank=1, both reqs high -> cpu_ack every cycle; vid_ack never.
REQ-042 SHALL cover: CPU write 0xA5 to 0x7FFF, then CPU read of 0x7FFF -> no cpu_valid after the write; cpu_valid after the read with cpu_dout=0xA5, held afterwards.
REQ-043 SHALL cover: reset asserted in the cycle after a CPU read ack -> no cpu_valid, cpu_dout=0x00, starve counter 0.
REQ-044 SHALL cover: no requests -> ram_we=0, no ack, and ram_addr unchanged from its last value.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared definitions for the video RAM arbiter.
// Grant-select encoding and default geometry.
package vram_pkg;

    // Which requester owns the RAM port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } gnt_e;

    // 32k x 8 video RAM.
    localparam int AW_DEF = 15;

    // Default starvation limit for the CPU.
    localparam int STARVE_DEF = 3;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter between video fetch and CPU.
// CPU wins in vblank or after STARVE_MAX denied cycles.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_DEF,
    parameter int AW         = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vblank,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic          vid_valid,
    output logic [7:0]    vid_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic          cpu_ack,
    output logic          cpu_valid,
    output logic [7:0]    cpu_dout,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_dout
);

    // A zero limit still needs a one-bit counter; it just never hits.
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    gnt_e          gnt;
    logic [SW-1:0] starve_cnt;
    logic          starve_hit;
    logic [AW-1:0] addr_q;
    logic          pend_vld;
    logic          pend_cpu;
    logic [7:0]    dout_q;
    logic          rd_issue;

    assign starve_hit = (STARVE_MAX > 0) && (starve_cnt == SMAX);

    // Grant select: starvation override, then vblank, then video.
    always_comb begin
        gnt = GNT_NONE;
        if (!reset) begin
            if (cpu_req && (starve_hit || vblank)) begin
                gnt = GNT_CPU;
            end else if (vid_req) begin
                gnt = GNT_VID;
            end else if (cpu_req) begin
                gnt = GNT_CPU;
            end
        end
    end

    // RAM port and ack outputs follow the granted requester.
    always_comb begin
        vid_ack  = 1'b0;
        cpu_ack  = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr_q;
        ram_din  = cpu_din;
        rd_issue = 1'b0;
        case (gnt)
            GNT_VID: begin
                vid_ack  = 1'b1;
                ram_addr = vid_addr;
                rd_issue = 1'b1;
            end
            GNT_CPU: begin
                cpu_ack  = 1'b1;
                ram_we   = cpu_we;
                ram_addr = cpu_addr;
                rd_issue = ~cpu_we;
            end
            default: begin
                ram_addr = addr_q;
            end
        endcase
    end

    // Starve counter, held address, pending-read owner, CPU data hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            addr_q     <= '0;
            pend_vld   <= 1'b0;
            pend_cpu   <= 1'b0;
            dout_q     <= 8'h00;
        end else begin
            if (!cpu_req || cpu_ack) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SMAX) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
            addr_q   <= ram_addr;
            pend_vld <= rd_issue;
            if (rd_issue) begin
                pend_cpu <= cpu_ack;
            end
            if (cpu_valid) begin
                dout_q <= ram_dout;
            end
        end
    end

    // Route returning read data to its owner; reset squashes it.
    always_comb begin
        vid_valid = pend_vld & ~pend_cpu & ~reset;
        cpu_valid = pend_vld & pend_cpu & ~reset;
        vid_data  = ram_dout;
        cpu_dout  = cpu_valid ? ram_dout : dout_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a registered RAM model
// and read-data scoreboards for both requesters.
module tb_vram_arbiter;

    localparam int AW = 15;

    logic          clk;
    logic          reset;
    logic          vblank;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          vid_valid;
    logic [7:0]    vid_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_ack;
    logic          cpu_valid;
    logic [7:0]    cpu_dout;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic [7:0]    ram_dout;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:(1<<AW)-1];
    logic       mem_init = 1'b0;

    logic [7:0] vq[$];
    logic [7:0] cq[$];
    logic       pv = 1'b0;
    logic       pc = 1'b0;

    vram_arbiter #(.STARVE_MAX(3), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .vblank   (vblank),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_valid(vid_valid),
        .vid_data (vid_data),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_ack  (cpu_ack),
        .cpu_valid(cpu_valid),
        .cpu_dout (cpu_dout),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM; output not updated on write cycles.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i] = 8'(i) ^ 8'h3C;
            end
            mem[15'h0123] = 8'h5A;
            mem_init = 1'b1;
        end
        if (ram_we) begin
            mem[ram_addr] = ram_din;
        end else begin
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check acks/valids/data mid-cycle, then
    // record what the RAM returns next cycle.
    task automatic cycle(input logic ev, input logic ec, input string tag);
        logic [7:0] e;
        @(negedge clk);
        chk({tag, ".vid_ack"}, 32'(vid_ack), 32'(ev));
        chk({tag, ".cpu_ack"}, 32'(cpu_ack), 32'(ec));
        chk({tag, ".vid_valid"}, 32'(vid_valid), 32'(pv & ~reset));
        chk({tag, ".cpu_valid"}, 32'(cpu_valid), 32'(pc & ~reset));
        if (vid_valid) begin
            if (vq.size() == 0) begin
                chk({tag, ".vq_empty"}, 32'(vq.size()), 32'd1);
            end else begin
                e = vq.pop_front();
                chk({tag, ".vid_data"}, 32'(vid_data), 32'(e));
            end
        end
        if (cpu_valid) begin
            if (cq.size() == 0) begin
                chk({tag, ".cq_empty"}, 32'(cq.size()), 32'd1);
            end else begin
                e = cq.pop_front();
                chk({tag, ".cpu_dout"}, 32'(cpu_dout), 32'(e));
            end
        end
        if (ev) begin
            chk({tag, ".vaddr"}, 32'(ram_addr), 32'(vid_addr));
            chk({tag, ".vwe"}, 32'(ram_we), 32'd0);
        end
        if (ec) begin
            chk({tag, ".caddr"}, 32'(ram_addr), 32'(cpu_addr));
            chk({tag, ".cwe"}, 32'(ram_we), 32'(cpu_we));
            if (cpu_we) begin
                chk({tag, ".cdin"}, 32'(ram_din), 32'(cpu_din));
            end
        end
        if (!ev && !ec) begin
            chk({tag, ".idle_we"}, 32'(ram_we), 32'd0);
        end
        if (reset) begin
            pv = 1'b0;
            pc = 1'b0;
            vq.delete();
            cq.delete();
        end else begin
            pv = ev;
            pc = ec & ~cpu_we;
            if (ev) vq.push_back(mem[vid_addr]);
            if (ec && !cpu_we) cq.push_back(mem[cpu_addr]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vblank   = 1'b0;
        vid_req  = 1'b0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        vblank   = 1'b0;
        vid_req  = 1'b0;
        vid_addr = '0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_din  = 8'h00;
        @(posedge clk);
        #1;

        // Reset: requests ignored while reset is high.
        vid_req = 1'b1;
        cpu_req = 1'b1;
        cycle(1'b0, 1'b0, "rst0");
        cycle(1'b0, 1'b0, "rst1");
        reset = 1'b0;
        idle_inputs();
        chk("rst.cpu_dout", 32'(cpu_dout), 32'h00);
        chk("rst.ram_addr", 32'(ram_addr), 32'h0);
        cycle(1'b0, 1'b0, "idle0");

        // Lone video read of 0x0123.
        vid_req  = 1'b1;
        vid_addr = 15'h0123;
        cycle(1'b1, 1'b0, "vrd");
        idle_inputs();
        cycle(1'b0, 1'b0, "vrd_ret");
        chk("vrd.ram_addr_hold", 32'(ram_addr), 32'h0123);

        // Contention outside vblank: V,V,V,C repeating.
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 15'h0010;
        for (int i = 0; i < 8; i++) begin
            vid_addr = 15'(16'h0400 + i);
            cycle((i % 4) != 3, (i % 4) == 3, $sformatf("starve%0d", i));
        end

        // Vblank: CPU every cycle, video never.
        vblank = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_addr = 15'(16'h0500 + i);
            cycle(1'b0, 1'b1, $sformatf("vbl%0d", i));
        end
        idle_inputs();
        cycle(1'b0, 1'b0, "vbl_ret");

        // Lone CPU read outside vblank.
        cpu_req  = 1'b1;
        cpu_addr = 15'h0200;
        cycle(1'b0, 1'b1, "crd");
        idle_inputs();
        cycle(1'b0, 1'b0, "crd_ret");

        // CPU write then read-back at the top address.
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 15'h7FFF;
        cpu_din  = 8'hA5;
        cycle(1'b0, 1'b1, "cwr");
        cpu_we   = 1'b0;
        cycle(1'b0, 1'b1, "crb");
        idle_inputs();
        cycle(1'b0, 1'b0, "crb_ret");
        cycle(1'b0, 1'b0, "hold");
        chk("hold.cpu_dout", 32'(cpu_dout), 32'hA5);
        chk("hold.ram_addr", 32'(ram_addr), 32'h7FFF);
        chk("hold.ram_we", 32'(ram_we), 32'd0);

        // Reset right after a CPU read ack squashes the return.
        vblank   = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 15'h0123;
        cycle(1'b0, 1'b1, "rd_pre_rst");
        reset   = 1'b1;
        vblank  = 1'b0;
        vid_req = 1'b1;
        cycle(1'b0, 1'b0, "rst_cyc");
        reset = 1'b0;
        idle_inputs();
        chk("rst2.cpu_dout", 32'(cpu_dout), 32'h00);
        chk("rst2.starve", 32'(dut.starve_cnt), 32'd0);
        chk("rst2.ram_addr", 32'(ram_addr), 32'h0);
        cycle(1'b0, 1'b0, "rst2_idle");

        // Counter restarts cleanly after reset.
        vid_req  = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 15'h0020;
        for (int i = 0; i < 4; i++) begin
            vid_addr = 15'(16'h0600 + i);
            cycle(i != 3, i == 3, $sformatf("post%0d", i));
        end
        idle_inputs();
        cycle(1'b0, 1'b0, "post_ret");
        cycle(1'b0, 1'b0, "end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
